bcd_time_counter: RTL
=====================

Name: bcd_time_counter

Overview:
Parametrised BCD time-of-day counter, successor to the fixed single-digit-chain watch. It counts seconds, minutes and hours as cascaded BCD digits, driven by an external enable tick with a programmable prescale. It supports 12/24-hour display mode, a validated time-load handshake and carry pulses. It sits between the tick generator and the display/decoder logic.

Parameters:
TICKS_PER_SEC, 1, number of tick_en pulses per second advance (1..1024)
PS_W, $clog2(TICKS_PER_SEC+1), prescaler width (derived, localparam)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
tick_en  in  1  single-cycle enable pulse from the tick generator
mode_24h  in  1  1 = 24-hour display, 0 = 12-hour display
set_valid  in  1  load request, sampled every cycle
set_hour  in  6  BCD hour, always 24h format: [5:4] tens, [3:0] ones
set_min  in  7  BCD minute: [6:4] tens, [3:0] ones
set_sec  in  7  BCD second: [6:4] tens, [3:0] ones
set_ack  out  1  1-cycle pulse: load accepted
set_err  out  1  1-cycle pulse: load rejected
hour_bcd  out  6  displayed hour, BCD
min_bcd  out  7  minute, BCD
sec_bcd  out  7  second, BCD
pm  out  1  12h mode: 1 = PM; forced 0 in 24h mode
min_tick  out  1  1-cycle pulse on seconds wrap 59->00
hour_tick  out  1  1-cycle pulse on minutes wrap 59->00
day_tick  out  1  1-cycle pulse on 23:59:59 -> 00:00:00

Behaviour:
- Reset: time 00:00:00 (24h internal), prescaler 0. set_ack, set_err, min_tick, hour_tick and day_tick are 0. In 12h mode the display reads 12 with pm=0.
- Internal state is always 24h BCD: sec ones 0-9, sec tens 0-5, min ones 0-9, min tens 0-5, and hour 00-23.
- Prescaler: counts tick_en. When the count equals TICKS_PER_SEC-1 and tick_en=1, the prescaler clears and seconds advance at that edge. With TICKS_PER_SEC=1, every tick_en advances.
- Cascade: each digit increments only when all lower digits are at their max in the same advance. The whole chain updates in one clock; there is no ripple latency.
  - Ones at 9 wrap to 0 and carry to tens.
  - Sec/min tens at 5 (with ones at 9) wrap to 0.
  - Hour at 23 wraps to 00. Hour ones wrap 9->0 only when tens < 2.
- Carry pulses are registered. They assert the same cycle the wrapped value appears on the outputs, and last exactly one cycle. On 23:59:59->00:00:00, min_tick, hour_tick and day_tick all assert together.
- Outputs are combinational decode of the state flops. Changing mode_24h alters the display in the same cycle without changing the time.
- 12h decode from internal hour H:
  - H=0 -> 12, pm=0
  - H=1..11 -> H, pm=0
  - H=12 -> 12, pm=1
  - H=13..23 -> H-12, pm=1
- Load:
  - When set_valid=1, the fields are checked: BCD ones <=9, sec/min tens <=5, hour <=23.
  - Valid: time is loaded at that edge, prescaler cleared, set_ack=1 the following cycle.
  - Invalid: state unchanged, set_err=1 the following cycle.
  - set_valid held high reloads every cycle.
- Simultaneous set_valid and advancing tick: the load wins and the tick is discarded. No carry pulses are produced by a load.
- Async reset mid-operation returns everything to reset values immediately. There is no partial state.

Optional Feature:
BCD_TIME_ALARM_EN
- Defined: adds inputs alm_load (1), alm_hour (6), alm_min (7), alm_arm (1) and output alm_hit (1).
  - The alarm register resets to 00:00 and loads on alm_load with the same range check as set. An invalid alarm load is ignored.
  - alm_hit is a 1-cycle pulse when alm_arm=1 and a tick advance produces HH:MM:00 equal to the alarm. It aligns with min_tick.
  - A time load landing on the alarm value does not fire alm_hit.
- Undefined: none of these ports or registers exist, and behaviour is otherwise identical.

Decomposition:
- Package bcd_time_pkg holds:
  - Constants SEC_TENS_MAX=5, MIN_TENS_MAX=5, HOUR_MAX_BCD=8'h23.
  - Typedef bcd_time_t {hour[5:0], min[6:0], sec[6:0]}.
  - A function bcd_time_valid().
- One sub-module, bcd_digit_cnt: parameter MAX, inputs inc/load/ld_val, outputs value and wrap. It is instantiated for the four sec/min digits. The hour uses dedicated logic because of the 23 wrap.

Test Plan:
- Reset, mode_24h=1 -> 00:00:00, all pulses 0. Switch mode_24h=0 -> hour_bcd=6'h12, pm=0.
- TICKS_PER_SEC=4, 8 tick_en pulses from 00:00:00 -> sec_bcd=7'h02, advancing on the 4th and 8th pulses only.
- Load 23:59:59 (set_ack next cycle), then one advance -> 00:00:00 with min_tick, hour_tick and day_tick high for exactly one cycle.
- Load 13:05:00 in 12h mode -> hour_bcd=6'h01, pm=1. Load 12:00:00 -> 6'h12, pm=1.
- Load with set_min=7'h60 or set_hour=6'h24 -> set_err pulse, time unchanged. Load coinciding with an advancing tick -> loaded value exact, no increment.
- ALARM_EN: alarm 07:30 armed, load 07:29:59, one advance -> alm_hit and min_tick together. Direct load 07:30:00 -> no alm_hit.

Source files
------------

// File: rtl/bcd_time_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bcd_time_pkg                                           |
// | Description : Shared limits, time record and range check for the BCD |
// |               time-of-day counter.                                   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package bcd_time_pkg;

    localparam int         SEC_TENS_MAX = 5;
    localparam int         MIN_TENS_MAX = 5;
    localparam logic [7:0] HOUR_MAX_BCD = 8'h23;

    typedef struct packed {
        logic [5:0] hour;
        logic [6:0] min;
        logic [6:0] sec;
    } bcd_time_t;

    function automatic logic bcd_hm_valid(input logic [5:0] hour, input logic [6:0] min);
        return (min[3:0] <= 4'd9) && (min[6:4] <= 3'(MIN_TENS_MAX)) &&
               (hour[3:0] <= 4'd9) && ({2'b00, hour} <= HOUR_MAX_BCD);
    endfunction

    function automatic logic bcd_time_valid(input bcd_time_t t);
        return bcd_hm_valid(t.hour, t.min) &&
               (t.sec[3:0] <= 4'd9) && (t.sec[6:4] <= 3'(SEC_TENS_MAX));
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_time_counter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bcd_time_counter_if                                    |
// | Description : Tick, load and display bundle of the BCD time counter. |
// |               BCD_TIME_ALARM_EN adds the alarm signals.              |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
interface bcd_time_counter_if;

    logic       tick_en;
    logic       mode_24h;
    logic       set_valid;
    logic [5:0] set_hour;
    logic [6:0] set_min;
    logic [6:0] set_sec;
    logic       set_ack;
    logic       set_err;
    logic [5:0] hour_bcd;
    logic [6:0] min_bcd;
    logic [6:0] sec_bcd;
    logic       pm;
    logic       min_tick;
    logic       hour_tick;
    logic       day_tick;
`ifdef BCD_TIME_ALARM_EN
    logic       alm_load;
    logic [5:0] alm_hour;
    logic [6:0] alm_min;
    logic       alm_arm;
    logic       alm_hit;

    modport master (
        output tick_en, mode_24h, set_valid, set_hour, set_min, set_sec,
               alm_load, alm_hour, alm_min, alm_arm,
        input  set_ack, set_err, hour_bcd, min_bcd, sec_bcd, pm,
               min_tick, hour_tick, day_tick, alm_hit
    );
    modport slave (
        input  tick_en, mode_24h, set_valid, set_hour, set_min, set_sec,
               alm_load, alm_hour, alm_min, alm_arm,
        output set_ack, set_err, hour_bcd, min_bcd, sec_bcd, pm,
               min_tick, hour_tick, day_tick, alm_hit
    );
`else
    modport master (
        output tick_en, mode_24h, set_valid, set_hour, set_min, set_sec,
        input  set_ack, set_err, hour_bcd, min_bcd, sec_bcd, pm,
               min_tick, hour_tick, day_tick
    );
    modport slave (
        input  tick_en, mode_24h, set_valid, set_hour, set_min, set_sec,
        output set_ack, set_err, hour_bcd, min_bcd, sec_bcd, pm,
               min_tick, hour_tick, day_tick
    );
`endif

endinterface
`default_nettype wire

// File: rtl/bcd_digit_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bcd_digit_cnt                                          |
// | Description : One BCD digit counting 0..MAX with load; wrap flags    |
// |               the increment that rolls MAX back to 0.                |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module bcd_digit_cnt #(
    parameter int MAX = 9,
    parameter int W   = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    input  wire logic         inc,
    input  wire logic         load,
    input  wire logic [W-1:0] ld_val,
    output logic      [W-1:0] value,
    output logic              wrap
);

    logic [W-1:0] value_q;
    logic [W-1:0] value_d;

    assign wrap  = inc && (value_q == W'(MAX));
    assign value = value_q;

    always_comb begin
        value_d = value_q;
        if (load) begin
            value_d = ld_val;
        end else if (inc) begin
            value_d = wrap ? '0 : value_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bcd_time_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bcd_time_counter                                       |
// | Description : Prescaled BCD time-of-day counter, 24h internal state, |
// |               12/24h display, checked load, carry pulses.            |
// |               Optional alarm compare: define BCD_TIME_ALARM_EN.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module bcd_time_counter
    import bcd_time_pkg::*;
#(
    parameter int TICKS_PER_SEC = 1
) (
    input wire logic           clk,
    input wire logic           rst,
    bcd_time_counter_if.slave  bus
);

    localparam int PS_W = $clog2(TICKS_PER_SEC + 1);

    bcd_time_t     set_time;
    logic          set_ok;
    logic          load_en;
    logic          ps_hit;
    logic          adv;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [5:0]    hour_q, hour_d;
    logic          ack_q, ack_d, err_q, err_d;
    logic          min_tick_q, min_tick_d, hour_tick_q, hour_tick_d, day_tick_q, day_tick_d;

    logic [3:0]    sec_ones, min_ones;
    logic [2:0]    sec_tens, min_tens;
    logic          sec_ones_wrap, sec_tens_wrap, min_ones_wrap, min_tens_wrap;
    logic          day_wrap;

    logic [4:0]    hour_bin;
    logic [4:0]    h12;
    logic [5:0]    hour_disp;
    logic          pm_disp;

    assign set_time = {bus.set_hour, bus.set_min, bus.set_sec};
    assign set_ok   = bcd_time_valid(set_time);
    assign load_en  = bus.set_valid && set_ok;
    assign ps_hit   = bus.tick_en && (ps_q == PS_W'(TICKS_PER_SEC - 1));
    // Any load request, accepted or not, swallows a coinciding advance.
    assign adv      = ps_hit && !bus.set_valid;

    bcd_digit_cnt #(.MAX(9), .W(4)) u_sec_ones (
        .clk(clk), .rst(rst), .inc(adv), .load(load_en),
        .ld_val(bus.set_sec[3:0]), .value(sec_ones), .wrap(sec_ones_wrap)
    );
    bcd_digit_cnt #(.MAX(SEC_TENS_MAX), .W(3)) u_sec_tens (
        .clk(clk), .rst(rst), .inc(sec_ones_wrap), .load(load_en),
        .ld_val(bus.set_sec[6:4]), .value(sec_tens), .wrap(sec_tens_wrap)
    );
    bcd_digit_cnt #(.MAX(9), .W(4)) u_min_ones (
        .clk(clk), .rst(rst), .inc(sec_tens_wrap), .load(load_en),
        .ld_val(bus.set_min[3:0]), .value(min_ones), .wrap(min_ones_wrap)
    );
    bcd_digit_cnt #(.MAX(MIN_TENS_MAX), .W(3)) u_min_tens (
        .clk(clk), .rst(rst), .inc(min_ones_wrap), .load(load_en),
        .ld_val(bus.set_min[6:4]), .value(min_tens), .wrap(min_tens_wrap)
    );

    assign day_wrap = min_tens_wrap && (hour_q == 6'(HOUR_MAX_BCD));

    always_comb begin
        ps_d        = ps_q;
        hour_d      = hour_q;
        ack_d       = bus.set_valid && set_ok;
        err_d       = bus.set_valid && !set_ok;
        min_tick_d  = sec_tens_wrap;
        hour_tick_d = min_tens_wrap;
        day_tick_d  = day_wrap;

        if (bus.set_valid) begin
            if (set_ok) begin
                ps_d = '0;
            end
        end else if (bus.tick_en) begin
            ps_d = ps_hit ? '0 : ps_q + PS_W'(1);
        end

        // Hour ones only roll 9->0 below 20; 23 rolls straight to 00.
        if (load_en) begin
            hour_d = bus.set_hour;
        end else if (min_tens_wrap) begin
            if (day_wrap) begin
                hour_d = '0;
            end else if (hour_q[3:0] == 4'd9) begin
                hour_d = {hour_q[5:4] + 2'd1, 4'd0};
            end else begin
                hour_d = {hour_q[5:4], hour_q[3:0] + 4'd1};
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ps_q        <= '0;
            hour_q      <= '0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            min_tick_q  <= 1'b0;
            hour_tick_q <= 1'b0;
            day_tick_q  <= 1'b0;
        end else begin
            ps_q        <= ps_d;
            hour_q      <= hour_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
            min_tick_q  <= min_tick_d;
            hour_tick_q <= hour_tick_d;
            day_tick_q  <= day_tick_d;
        end
    end

    // 12h display decode; the subtraction is done in binary and re-encoded.
    always_comb begin
        hour_bin  = 5'(hour_q[5:4]) * 5'd10 + {1'b0, hour_q[3:0]};
        h12       = 5'd0;
        hour_disp = hour_q;
        pm_disp   = 1'b0;
        if (!bus.mode_24h) begin
            if (hour_bin == 5'd0) begin
                hour_disp = 6'h12;
            end else if (hour_bin < 5'd12) begin
                hour_disp = hour_q;
            end else begin
                pm_disp = 1'b1;
                if (hour_bin == 5'd12) begin
                    hour_disp = 6'h12;
                end else begin
                    h12       = hour_bin - 5'd12;
                    hour_disp = (h12 >= 5'd10) ? {2'b01, 4'(h12 - 5'd10)}
                                               : {2'b00, h12[3:0]};
                end
            end
        end
    end

    assign bus.hour_bcd  = hour_disp;
    assign bus.pm        = pm_disp;
    assign bus.min_bcd   = {min_tens, min_ones};
    assign bus.sec_bcd   = {sec_tens, sec_ones};
    assign bus.set_ack   = ack_q;
    assign bus.set_err   = err_q;
    assign bus.min_tick  = min_tick_q;
    assign bus.hour_tick = hour_tick_q;
    assign bus.day_tick  = day_tick_q;

`ifdef BCD_TIME_ALARM_EN
    logic [5:0] alm_hour_q, alm_hour_d;
    logic [6:0] alm_min_q, alm_min_d;
    logic       alm_hit_q, alm_hit_d;
    logic [6:0] min_next;

    // Minute value the cascade will present after a seconds wrap.
    always_comb begin
        min_next   = {min_tens, min_ones + 4'd1};
        if (min_ones_wrap) begin
            min_next = {min_tens_wrap ? 3'd0 : min_tens + 3'd1, 4'd0};
        end
        alm_hour_d = alm_hour_q;
        alm_min_d  = alm_min_q;
        if (bus.alm_load && bcd_hm_valid(bus.alm_hour, bus.alm_min)) begin
            alm_hour_d = bus.alm_hour;
            alm_min_d  = bus.alm_min;
        end
        alm_hit_d = bus.alm_arm && sec_tens_wrap &&
                    (hour_d == alm_hour_q) && (min_next == alm_min_q);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alm_hour_q <= '0;
            alm_min_q  <= '0;
            alm_hit_q  <= 1'b0;
        end else begin
            alm_hour_q <= alm_hour_d;
            alm_min_q  <= alm_min_d;
            alm_hit_q  <= alm_hit_d;
        end
    end

    assign bus.alm_hit = alm_hit_q;
`endif

endmodule
`default_nettype wire
